// File: rtl/frame_sync_config_scheduler.sv
// Holds host configuration writes in a FIFO and replays only committed transactions
// onto the command port at frame boundaries, so a frame never sees mixed parameters.
module frame_sync_config_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  host_valid_i,
  output logic                  host_ready_o,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_data_i,
  input  logic                  host_last_i,
  input  logic                  host_abort_i,
  input  logic                  frame_end_i,
  input  logic                  frame_start_i,
  output logic                  cmd_valid_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  output logic                  pending_o,
  output logic                  late_o,
  output logic [15:0]           frames_applied_o
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_q, wr_d;
  logic [PTR_W-1:0]      rd_q, rd_d;
  logic [PTR_W-1:0]      commit_q, commit_d;
  logic [PTR_W-1:0]      drain_left_q, drain_left_d;
  logic [0:0]            state_q, state_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic                  late_q, late_d;
  logic [15:0]           frames_q, frames_d;

  logic [PTR_W-1:0]   occupancy;
  logic [PTR_W-1:0]   committed_cnt;
  logic               full;
  logic               push;
  logic [ENTRY_W-1:0] rd_entry;

  // The extra pointer bit distinguishes a full FIFO from an empty one.
  assign occupancy     = wr_q - rd_q;
  assign committed_cnt = commit_q - rd_q;
  assign full          = (occupancy == PTR_W'(DEPTH));
  assign host_ready_o  = !full && !host_abort_i;
  assign push          = host_valid_i && host_ready_o;
  assign rd_entry      = mem_q[rd_q[IDX_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q[IDX_W-1:0]] <= {host_addr_i, host_data_i};
    end
  end

  always_comb begin
    wr_d         = wr_q;
    rd_d         = rd_q;
    commit_d     = commit_q;
    drain_left_d = drain_left_q;
    state_d      = state_q;
    cmd_valid_d  = 1'b0;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    late_d       = late_q;
    frames_d     = frames_q;

    // Abort rewinds only the uncommitted tail; committed and in-flight entries are untouched.
    if (host_abort_i) begin
      wr_d = commit_q;
    end else if (push) begin
      wr_d = wr_q + 1'b1;
      if (host_last_i) begin
        commit_d = wr_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_end_i && (committed_cnt != '0)) begin
          drain_left_d = committed_cnt;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cmd_valid_d  = 1'b1;
        cmd_addr_d   = rd_entry[ENTRY_W-1:DATA_WIDTH];
        cmd_data_d   = rd_entry[DATA_WIDTH-1:0];
        rd_d         = rd_q + 1'b1;
        drain_left_d = drain_left_q - 1'b1;
        if (frame_start_i) begin
          late_d = 1'b1;
        end
        if (drain_left_q == PTR_W'(1)) begin
          state_d  = ST_IDLE;
          frames_d = frames_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q         <= '0;
      rd_q         <= '0;
      commit_q     <= '0;
      drain_left_q <= '0;
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      late_q       <= 1'b0;
      frames_q     <= '0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      commit_q     <= commit_d;
      drain_left_q <= drain_left_d;
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      late_q       <= late_d;
      frames_q     <= frames_d;
    end
  end

  assign cmd_valid_o      = cmd_valid_q;
  assign cmd_addr_o       = cmd_addr_q;
  assign cmd_data_o       = cmd_data_q;
  assign pending_o        = (committed_cnt != '0);
  assign late_o           = late_q;
  assign frames_applied_o = frames_q;

endmodule

// File: tb/tb_frame_sync_config_scheduler.sv
// Scoreboard bench: stimulus queues expected command writes, a negedge monitor checks them.
module tb_frame_sync_config_scheduler;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_valid, host_ready, host_last, host_abort;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          frame_end, frame_start;
  logic          cmd_valid;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          pending, late;
  logic [15:0]   frames;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_exp;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_sync_config_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_valid_i(host_valid), .host_ready_o(host_ready),
    .host_addr_i(host_addr), .host_data_i(host_data),
    .host_last_i(host_last), .host_abort_i(host_abort),
    .frame_end_i(frame_end), .frame_start_i(frame_start),
    .cmd_valid_o(cmd_valid), .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data),
    .pending_o(pending), .late_o(late), .frames_applied_o(frames)
  );

  // Monitor: every command write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got addr=0x%0h data=0x%0h, required no write", cmd_addr, cmd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({cmd_addr, cmd_data} !== mon_exp) begin
          errors++;
          $display("FAIL cmd_write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                   cmd_addr, cmd_data, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
        end else begin
          $display("cmd write addr=0x%0h data=0x%0h ok", cmd_addr, cmd_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("check %s = 0x%0h ok", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    host_last  = last;
    step();
    host_valid = 1'b0;
    host_last  = 1'b0;
    $display("push addr=0x%0h data=0x%0h last=%0b", a, d, last);
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    $display("frame_end pulse");
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: drain incomplete, %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    host_valid = 1'b0; host_last = 1'b0; host_abort = 1'b0;
    host_addr = '0; host_data = '0;
    frame_end = 1'b0; frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst_cmd_data", cmd_data, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_late", 32'(late), 32'd0);
    check("rst_frames", 32'(frames), 32'd0);
    step();

    // Basic three-write transaction
    push(16'h10, 32'h100, 1'b0); exp_q.push_back({16'h10, 32'h100});
    push(16'h11, 32'h0,   1'b0); exp_q.push_back({16'h11, 32'h0});
    check("pending_uncommitted", 32'(pending), 32'd0);
    push(16'h12, 32'h40,  1'b1); exp_q.push_back({16'h12, 32'h40});
    check("pending_after_last", 32'(pending), 32'd1);
    pulse_frame_end();
    wait_drain("t1_drain");
    check("t1_frames", 32'(frames), 32'd1);
    check("t1_pending", 32'(pending), 32'd0);

    // Abort drops uncommitted writes only
    push(16'h20, 32'h1, 1'b0);
    push(16'h21, 32'h2, 1'b0);
    host_abort = 1'b1;
    step();
    host_abort = 1'b0;
    push(16'h50, 32'h10, 1'b1); exp_q.push_back({16'h50, 32'h10});
    pulse_frame_end();
    wait_drain("t2_drain");
    check("t2_frames", 32'(frames), 32'd2);

    // Fill the FIFO completely
    for (int i = 0; i < DEPTH; i++) begin
      push(16'(16'h100 + i), 32'(32'hA000 + i), (i == DEPTH - 1));
      exp_q.push_back({16'(16'h100 + i), 32'(32'hA000 + i)});
      if (i == DEPTH - 2) check("t3_ready_before_full", 32'(host_ready), 32'd1);
    end
    check("t3_ready_full", 32'(host_ready), 32'd0);
    pulse_frame_end();
    check("t3_ready_before_pop", 32'(host_ready), 32'd0);
    step();
    check("t3_ready_after_pop", 32'(host_ready), 32'd1);
    wait_drain("t3_drain");
    check("t3_frames", 32'(frames), 32'd3);

    // Commits and frame_start during a drain
    for (int i = 0; i < 5; i++) begin
      push(16'(16'h200 + i), 32'(i * 3), (i == 4));
      exp_q.push_back({16'(16'h200 + i), 32'(i * 3)});
    end
    pulse_frame_end();
    push(16'h300, 32'h33, 1'b0);
    frame_start = 1'b1;
    push(16'h301, 32'h44, 1'b1);
    frame_start = 1'b0;
    wait_drain("t4_drain");
    check("t4_late", 32'(late), 32'd1);
    check("t4_pending", 32'(pending), 32'd1);
    check("t4_frames", 32'(frames), 32'd4);
    exp_q.push_back({16'h300, 32'h33});
    exp_q.push_back({16'h301, 32'h44});
    pulse_frame_end();
    wait_drain("t4_second_drain");
    check("t4_frames2", 32'(frames), 32'd5);
    check("t4_pending2", 32'(pending), 32'd0);

    // Boundary with nothing committed
    pulse_frame_end();
    repeat (4) step();
    check("t5_frames_empty", 32'(frames), 32'd5);

    // Reset in the second cycle of a four-entry drain
    for (int i = 0; i < 4; i++) begin
      push(16'(16'h400 + i), 32'(i), (i == 3));
      exp_q.push_back({16'(16'h400 + i), 32'(i)});
    end
    pulse_frame_end();
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("t5_rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("t5_rst_pending", 32'(pending), 32'd0);
    check("t5_writes_before_rst", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    step();
    rst = 1'b0;
    #1;
    check("t5_frames_rst", 32'(frames), 32'd0);
    check("t5_late_rst", 32'(late), 32'd0);
    check("t5_ready_rst", 32'(host_ready), 32'd1);
    pulse_frame_end();
    repeat (4) step();
    check("t5_no_drain_after_rst", 32'(frames), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_sync_config_scheduler.md
# frame_sync_config_scheduler

Buffers host configuration writes (homography coefficients, ROI corners, DfDD constants, confidence minimum) and replays them onto the controller's command-interface write port only at frame boundaries, so one frame never mixes old and new parameters. Sits between the host command source (UART/SPI bridge) and the parameter controller. Writes are grouped into committed transactions; each frame boundary applies every transaction committed before that boundary, back-to-back, one write per clock.

## Interface
- ADDR_WIDTH, 16, command address width; matches the command interface.
- DATA_WIDTH, 32, command data width; matches the command interface.
- DEPTH, 32, write FIFO entries; power of 2, at least 4.
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  asynchronous, active-high reset.
- host_valid_i  in  1  host write request.
- host_ready_o  out  1  write accepted on a cycle with host_valid_i=1 and host_ready_o=1.
- host_addr_i  in  ADDR_WIDTH  write address.
- host_data_i  in  DATA_WIDTH  write data.
- host_last_i  in  1  this write closes and commits the current transaction.
- host_abort_i  in  1  discard all uncommitted entries.
- frame_end_i  in  1  one-cycle pulse at the start of vertical blanking.
- frame_start_i  in  1  one-cycle pulse at the first active pixel.
- cmd_valid_o  out  1  registered; drives the command-interface valid.
- cmd_addr_o  out  ADDR_WIDTH  registered; drives the command-interface address.
- cmd_data_o  out  DATA_WIDTH  registered; drives the command-interface data.
- pending_o  out  1  committed entries are waiting for a boundary.
- late_o  out  1  sticky; a frame_start_i arrived during a drain.
- frames_applied_o  out  16  count of drains completed; wraps at 2^16.

## Operation
- Storage: circular FIFO (write pointer wr, read pointer rd, occupancy count).
- commit_ptr marks the end of the committed region.
- committed_cnt = commit_ptr - rd, modulo DEPTH, with full-occupancy handled via the extra pointer bit.
- Push: occurs when host_valid_i and host_ready_o are both 1. The push stores {addr, data} and advances wr. If host_last_i=1, commit_ptr becomes the new wr.
- host_ready_o = !full && !host_abort_i. A push is never accepted in an abort cycle.
- Abort: wr is reset to commit_ptr, which drops uncommitted entries. This is legal in any state and never touches committed or snapshot entries.
- FSM states:
  - IDLE: on frame_end_i with committed_cnt>0, load drain_left = committed_cnt (snapshot) and go to DRAIN. On frame_end_i with committed_cnt=0, stay in IDLE.
  - DRAIN: each cycle, pop the entry at rd into the cmd_* registers with cmd_valid_o=1, advance rd, and decrement drain_left. After the pop where drain_left reaches 0, go to IDLE and increment frames_applied_o.
- Commits that land during DRAIN are not in the snapshot. They wait for the next frame_end_i.
- frame_end_i is ignored in DRAIN.
- frame_start_i during DRAIN sets late_o. The drain continues to completion, because atomicity takes precedence.
- Simultaneous push and pop in one cycle are both performed. Occupancy is unchanged, and full is evaluated on the pre-cycle occupancy.
- FIFO full with committed_cnt=0: the host must abort. The block does not self-recover.
- pending_o = committed_cnt>0, combinational from the registered pointers.
- cmd_addr_o and cmd_data_o hold their last value when cmd_valid_o=0.

## Timing
- Reset values:
  - cmd_valid_o=0, cmd_addr_o=0, cmd_data_o=0.
  - Pointers, drain_left and frames_applied_o = 0; late_o=0.
  - State = IDLE, pending_o=0, host_ready_o=1 (once rst_i is deasserted).
- Reset asserted mid-drain clears the outputs immediately (asynchronously). All buffered entries are lost.
- frame_end_i sampled at edge N (IDLE, K committed entries): the state is DRAIN after edge N.
- cmd_valid_o is high for the K cycles following edges N+1 .. N+K. The FSM is in IDLE after edge N+K.
- frames_applied_o increments at edge N+K.
- Entries drain in FIFO order: one per cycle, no gaps, no reordering.
- Push-to-pending latency: pending_o is high the cycle after the accepted write with host_last_i=1.
- A write committed at the same edge as frame_end_i is sampled is not included in that drain.

## Test plan
- Reset, then three writes (0x10=0x100, 0x11=0, 0x12=0x40, the last with host_last_i=1), then frame_end_i → cmd_valid_o high for exactly 3 cycles carrying those pairs in order; frames_applied_o=1; pending_o=0.
- Two uncommitted writes, host_abort_i, one write 0x50=0x0010 with last, frame_end_i → only 0x50=0x0010 issued.
- Fill DEPTH=32 entries with last on the 32nd → host_ready_o=0 after the 32nd push. frame_end_i → 32 drained writes; host_ready_o returns to 1 the cycle after the first pop.
- During a 5-entry drain: push 2 new writes with last and pulse frame_start_i → exactly 5 cmd writes, late_o=1, pending_o=1. The next frame_end_i drains the 2 new writes.
- frame_end_i with nothing committed → no cmd_valid_o and frames_applied_o unchanged. Then assert rst_i on the 2nd cycle of a 4-entry drain → cmd_valid_o=0 immediately and pending_o=0.
